md_unit: RTL and testbench
==========================

# md_unit

Iterative multiply/divide unit with architectural HI/LO registers. It sits beside `ALU` in the execute stage, takes the same A/B operand pair, and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO. HI/LO feed the writeback mux for MFHI/MFLO. `busy` stalls the datapath while an iterative operation is in flight.

## Interface
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `A` input 32: operand rs; dividend/multiplicand; source for MTHI/MTLO.
- `B` input 32: operand rt; divisor/multiplier.
- `MDOp` input 3: operation code, defined in `ENCODE.v`:
  - `MD_NOP`=0
  - `MD_MULT`=1
  - `MD_MULTU`=2
  - `MD_DIV`=3
  - `MD_DIVU`=4
  - `MD_MTHI`=5
  - `MD_MTLO`=6
  - 7 is treated as NOP.
- `busy` output 1: an iterative operation is in flight; the CPU holds PC and `MDOp`.
- `done` output 1: one-cycle pulse in the cycle after HI/LO receive an iterative result.
- `HI` output 32: HI register.
- `LO` output 32: LO register.

## Operation
- States: IDLE and RUN. A 6-bit cycle counter runs in RUN.
- IDLE, MULT/MULTU/DIV/DIVU sampled:
  - Latch operand magnitudes; for unsigned ops, use raw values.
  - Latch result-sign flags, clear the accumulator, set counter=32, go to RUN.
- IDLE, MTHI/MTLO: write A into HI/LO at that edge. Single cycle, no `busy`.
- RUN:
  - Multiply: one shift-add step per cycle over a 64-bit accumulator.
  - Divide: one restoring step per cycle over a 64-bit remainder/quotient register.
  - Counter decrements every cycle.
  - On the edge where the counter goes 1→0: apply sign correction, write HI/LO, return to IDLE, and set `done` for the following cycle.
- Result rules:
  - MULT/MULTU: {HI,LO} = 64-bit product.
  - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Divide by zero (B=0): HI=A, LO=32'hFFFF_FFFF for both DIV and DIVU. The full 32 cycles still elapse.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- `MDOp` other than NOP while `busy`: ignored. HI/LO are never written mid-operation.
- HI/LO outputs hold their old values until the final edge; no partial results are exposed.
- Reset mid-operation: immediate abort. State→IDLE, counter=0, accumulator cleared.

## Timing
- Reset values: `busy`=0, `done`=0, `HI`=0, `LO`=0, state IDLE.
- Op sampled at edge E0.
- `busy`=1 from E0 through E32.
- HI/LO updated at E32.
- `busy`=0 and `done`=1 in the cycle after E32.
- Latency: 32 cycles from accept to result visible.
- Back-to-back: a new op may be presented in the `done` cycle and is accepted at the next edge.
- `busy` is a registered output; it is not combinational on `MDOp`.
- MTHI/MTLO: result visible the cycle after the sampling edge.

## Configuration
- Macro: `MD_FAST_MUL_EN`.
- Defined:
  - MULT/MULTU use a combinational 64-bit multiplier and write HI/LO at the accept edge.
  - `busy` is never asserted for multiply; `done` pulses the next cycle.
  - Divide is unchanged.
- Undefined: all four arithmetic ops are iterative, 32 cycles as above.

## Test plan
- Reset mid-operation:
  - Stimulus: MULT A=7, B=6; assert `rst` at cycle 10.
  - Response: HI=LO=0 and `busy`=0 immediately; a following MTLO A=5 yields LO=5.
- Signed MULT:
  - Stimulus: MULT A=32'hFFFF_FFFE (-2), B=3.
  - Response: after 32 busy cycles, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA, `done` one cycle.
  - With `MD_FAST_MUL_EN` defined, the same values appear with no `busy`.
- MULTU:
  - Stimulus: MULTU A=B=32'hFFFF_FFFF.
  - Response: HI=32'hFFFF_FFFE, LO=32'h0000_0001.
- DIV/DIVU:
  - Stimulus: DIV A=-7, B=2.
  - Response: LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1).
  - Stimulus: DIVU A=7, B=2.
  - Response: LO=3, HI=1.
- Divide corner cases:
  - Stimulus: DIVU A=9, B=0.
  - Response: HI=9, LO=32'hFFFF_FFFF after 32 cycles.
  - Stimulus: DIV 32'h8000_0000 / -1.
  - Response: LO=32'h8000_0000, HI=0.
- Ops while busy:
  - Stimulus: issue MTHI A=32'h1234 at cycle 5 of a running DIV.
  - Response: the MTHI is ignored; HI holds only the DIV remainder at completion.
  - Stimulus: issue a new DIVU in the `done` cycle.
  - Response: it is accepted, and `busy` re-asserts the following cycle.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit with architectural HI/LO registers.
// Handshake: an op on MDOp is accepted on a rising edge only while busy is low;
// busy is registered and stays high until the edge that writes HI/LO; done
// pulses for one cycle after that edge. Ops other than NOP are ignored while
// busy is high.
// Optional feature macro: MD_FAST_MUL_EN (single-cycle combinational multiply).
module md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDOp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  // Opcodes 0 and 7 are no-ops and need no decode.
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               state_q, state_d;
  logic [5:0]           cnt_q;
  logic [2*WIDTH-1:0]   acc_q;      // product accumulator or {remainder, quotient}
  logic [WIDTH-1:0]     opb_q;      // multiplicand or divisor magnitude
  logic                 op_div_q;
  logic                 neg_lo_q;   // negate product / quotient
  logic                 neg_hi_q;   // negate remainder (dividend was negative)
  logic                 divzero_q;
  logic                 start, finish;

  logic                 is_mul, is_div, signed_op, iter_req;
  logic [WIDTH-1:0]     a_mag, b_mag;

  always_comb begin
    is_mul    = (MDOp == MD_MULT) || (MDOp == MD_MULTU);
    is_div    = (MDOp == MD_DIV)  || (MDOp == MD_DIVU);
    signed_op = (MDOp == MD_MULT) || (MDOp == MD_DIV);
`ifdef MD_FAST_MUL_EN
    iter_req  = is_div;
`else
    iter_req  = is_mul || is_div;
`endif
    a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
    b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
  end

  // One shift-add multiply step and one restoring divide step over acc_q.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_part;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_res;
  logic [WIDTH-1:0]     res_hi, res_lo;

  // Iteration step and sign-corrected final result.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_part = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = div_part >= {1'b0, opb_q};
    div_rem  = div_ge ? (div_part[WIDTH-1:0] - opb_q) : div_part[WIDTH-1:0];
    div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};
    prod_res = neg_lo_q ? -mul_next : mul_next;
    if (op_div_q) begin
      res_hi = neg_hi_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
      if (divzero_q)
        res_lo = '1;
      else
        res_lo = neg_lo_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    end else begin
      res_hi = prod_res[2*WIDTH-1:WIDTH];
      res_lo = prod_res[WIDTH-1:0];
    end
  end

`ifdef MD_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  // Single-cycle product; sign-extend operands for the signed form.
  always_comb begin
    if (MDOp == MD_MULT)
      fast_prod = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    else
      fast_prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept in IDLE, leave RUN on the last iteration.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: if (iter_req) begin
        start   = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: if (cnt_q == 6'd1) begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, counter and architectural HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      op_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      divzero_q <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc_q     <= {{WIDTH{1'b0}}, a_mag};
        opb_q     <= b_mag;
        cnt_q     <= 6'(WIDTH);
        op_div_q  <= is_div;
        neg_lo_q  <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
        neg_hi_q  <= signed_op && A[WIDTH-1];
        divzero_q <= (B == '0);
      end else if (state_q == S_RUN) begin
        acc_q <= op_div_q ? div_next : mul_next;
        cnt_q <= cnt_q - 6'd1;
        if (finish) begin
          HI   <= res_hi;
          LO   <= res_lo;
          done <= 1'b1;
        end
      end else begin
        case (MDOp)
          MD_MTHI: HI <= A;
          MD_MTLO: LO <= A;
`ifdef MD_FAST_MUL_EN
          MD_MULT, MD_MULTU: begin
            HI   <= fast_prod[2*WIDTH-1:WIDTH];
            LO   <= fast_prod[WIDTH-1:0];
            done <= 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign busy = (state_q == S_RUN);

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit with a plain-arithmetic reference.
module tb_md_unit;
  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                         DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6;
`ifdef MD_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  logic [2:0]  MDOp;
  logic        busy, done;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] hi_m, lo_m;

  md_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .MDOp(MDOp),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {HI,LO} from the architectural rules using 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MULT:  begin p = sa * sb; return p; end
      MULTU: return ua * ub;
      DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {hi_m, lo_m};
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got HI=%h LO=%h expected no result", HI, LO);
      end else begin
        check("result_hilo", {HI, LO}, exp_q.pop_front());
      end
    end
  end

  // Driver: present op at a falling edge, then follow it to completion.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit mt_mid);
    logic [63:0] r;
    logic [63:0] hilo0;
    bit iter, fastm, busy_ok, stable_ok;
    int n;
    iter  = (op == DIV) || (op == DIVU) || (!FAST && (op == MULT || op == MULTU));
    fastm = FAST && (op == MULT || op == MULTU);
    hilo0 = {HI, LO};
    MDOp = op; A = a; B = b;
    if (iter || fastm) begin
      r = ref_result(op, a, b);
      exp_q.push_back(r);
      {hi_m, lo_m} = r;
    end else if (op == MTHI) hi_m = a;
    else if (op == MTLO) lo_m = a;
    @(negedge clk);
    MDOp = NOP; A = $urandom; B = $urandom;
    if (iter) begin
      busy_ok = 1'b1;
      stable_ok = 1'b1;
      n = 1;
      while (done !== 1'b1 && n < 40) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if ({HI, LO} !== hilo0) stable_ok = 1'b0;
        if (mt_mid && n == 5) begin MDOp = MTHI; A = 32'h1234; end
        @(negedge clk);
        MDOp = NOP;
        n++;
      end
      check("busy_during_op", 64'(busy_ok), 64'd1);
      check("hilo_stable_during_op", 64'(stable_ok), 64'd1);
      check("latency", 64'(n), 64'd33);
      check("busy_after_op", 64'(busy), 64'd0);
    end else begin
      check("busy_idle", 64'(busy), 64'd0);
      check("hi", 64'(HI), 64'(hi_m));
      check("lo", 64'(LO), 64'(lo_m));
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; MDOp = NOP; A = '0; B = '0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a multiply.
    MDOp = MULT; A = 32'd7; B = 32'd6;
    if (FAST) exp_q.push_back(64'd42);
    @(negedge clk);
    MDOp = NOP;
    if (!FAST) check("busy_before_abort", 64'(busy), 64'd1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_hilo", {HI, LO}, 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    hi_m = '0; lo_m = '0;
    run_op(MTLO, 32'd5, 32'd0, 1'b0);

    // Directed cases.
    run_op(MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(DIVU,  32'd7, 32'd2, 1'b0);
    run_op(DIVU,  32'd9, 32'd0, 1'b0);
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(DIV,   32'h8000_0005, 32'd0, 1'b0);
    run_op(MTHI,  32'hCAFE_0001, 32'd0, 1'b0);
    run_op(DIV,   32'd100, 32'hFFFF_FFF9, 1'b1);   // MTHI issued mid-op is ignored
    run_op(DIVU,  32'hDEAD_BEEF, 32'd13, 1'b0);    // issued in the done cycle
    run_op(3'd7,  32'h5555_5555, 32'd1, 1'b0);

    // Randomized ops, each issued in the cycle after the previous completes.
    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #1ms;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
